// File: rtl/cdb_arbiter.sv
// Common Data Bus transmit end: per-FU result FIFOs feeding a round-robin
// arbiter that broadcasts one registered tag/value pair per cycle.

package cdb_pkg;
  typedef logic [3:0] RS_tag_type;
  localparam RS_tag_type INVALID   = 4'h0;
  localparam RS_tag_type ALU_RS    = 4'h1;
  localparam RS_tag_type LOAD_RS   = 4'h2;
  localparam RS_tag_type STORE_RS  = 4'h3;
  localparam RS_tag_type BRANCH_RS = 4'h4;

  typedef struct packed {
    RS_tag_type  tag;
    logic [31:0] data;
  } cdb_t;
endpackage

// One result buffer per functional unit.
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  cdb_t          din_i,
  output cdb_t          head_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cdb_t          mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= nxt(wr_q);
      end
      if (pop_i) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   FLUSH,
  input  logic [NUM_FU-1:0]      FU_VALID,
  input  RS_tag_type [NUM_FU-1:0] FU_TAG,
  input  logic [NUM_FU-1:0][31:0] FU_DATA,
  output logic [NUM_FU-1:0]      FU_READY,
  output cdb_t                   CDB_OUT,
  output logic                   PENDING
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int RW = $clog2(NUM_FU);

  logic [NUM_FU-1:0][CW-1:0] cnt;
  cdb_t [NUM_FU-1:0]         head;
  logic [NUM_FU-1:0]         push, pop, nonempty;

  logic [RW-1:0] rr_q, rr_d, win;
  logic          found;
  cdb_t          cdb_q, cdb_d;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    assign nonempty[g] = (cnt[g] != '0);
    assign FU_READY[g] = (cnt[g] != CW'(FIFO_DEPTH));
    assign push[g]     = FU_VALID[g] & FU_READY[g] & (FU_TAG[g] != INVALID) & ~FLUSH;
    assign pop[g]      = found & (win == RW'(g));

    cdb_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
      .clk_i   (CLK),
      .rst_n_i (RST_N),
      .flush_i (FLUSH),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .din_i   ({FU_TAG[g], FU_DATA[g]}),
      .head_o  (head[g]),
      .count_o (cnt[g])
    );
  end

  // Scan offsets from high to low so the smallest offset from rr_q wins.
  always_comb begin
    logic [RW:0] sum;
    win   = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      sum = {1'b0, rr_q} + (RW + 1)'(k);
      if (sum >= (RW + 1)'(NUM_FU)) sum = sum - (RW + 1)'(NUM_FU);
      if (nonempty[sum[RW-1:0]]) begin
        found = 1'b1;
        win   = sum[RW-1:0];
      end
    end
  end

  always_comb begin
    rr_d       = rr_q;
    cdb_d.tag  = INVALID;
    cdb_d.data = '0;
    if (found) begin
      cdb_d = head[win];
      rr_d  = (win == RW'(NUM_FU - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N || FLUSH) begin
      rr_q       <= '0;
      cdb_q.tag  <= INVALID;
      cdb_q.data <= '0;
    end else begin
      rr_q  <= rr_d;
      cdb_q <= cdb_d;
    end
  end

  assign CDB_OUT = cdb_q;
  assign PENDING = |nonempty;
endmodule
